// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU-side peripheral bus master: state encoding
// and default bus geometry.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam int DEF_ADDR_BUS_WIDTH = 32;
    localparam int DEF_DATA_BUS_WIDTH = 8;
    localparam int DEF_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/cpu_bus_master_if.sv
// CPU request/response channel of the bus master.
// Handshake: a request transfers on a rising edge where req_valid and req_ready
// are both high; resp_valid is a one-cycle pulse carrying resp_rdata/resp_err.
interface cpu_bus_master_if #(
    parameter int ADDR_BUS_WIDTH = 32,
    parameter int DATA_BUS_WIDTH = 8
);
    import cpu_bus_pkg::*;

    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [ADDR_BUS_WIDTH-1:0] req_addr;
    logic [DATA_BUS_WIDTH-1:0] req_wdata;
    logic                      resp_valid;
    logic [DATA_BUS_WIDTH-1:0] resp_rdata;
    logic                      resp_err;
    state_t                    state;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, state
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, state
    );

endinterface

// File: rtl/bus_timeout_counter.sv
// Counts ACCESS cycles without a completion; terminal flags the last allowed
// cycle so the master can end the access with an error on that edge.
module bus_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] count;

    assign terminal = (count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/cpu_bus_master.sv
// Bus master: takes one CPU request at a time, runs a strobed bus cycle until
// the device raises fc_bus or the timeout expires, then reports the result.
module cpu_bus_master
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_BUS_WIDTH = DEF_ADDR_BUS_WIDTH,
    parameter int DATA_BUS_WIDTH = DEF_DATA_BUS_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst,
    cpu_bus_master_if.slave           cpu,
    output logic [ADDR_BUS_WIDTH-1:0] addr_bus,
    inout  wire  [DATA_BUS_WIDTH-1:0] data_bus,
    output logic                      wr_bus,
    output logic                      rd_bus,
    input  logic                      fc_bus
);
    state_t                    state, state_next;
    logic                      write_q;
    logic [DATA_BUS_WIDTH-1:0] wdata_q;
    logic [DATA_BUS_WIDTH-1:0] resp_rdata_q;
    logic                      resp_err_q;
    logic                      fc_done;
    logic                      accept, finish_ok, finish_to;
    logic                      cnt_clear, cnt_en, cnt_term;

    // A floating or unknown fc_bus must never complete a cycle.
    assign fc_done = (fc_bus == 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish_ok  = 1'b0;
        finish_to  = 1'b0;
        cnt_clear  = 1'b0;
        cnt_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cpu.req_valid) begin
                    accept     = 1'b1;
                    cnt_clear  = 1'b1;
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (fc_done) begin
                    finish_ok  = 1'b1;
                    state_next = ST_RELEASE;
                end else if (cnt_term) begin
                    finish_to  = 1'b1;
                    state_next = ST_RELEASE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_RELEASE: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_bus     <= '0;
            wr_bus       <= 1'b0;
            rd_bus       <= 1'b0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_bus <= cpu.req_addr;
                write_q  <= cpu.req_write;
                wdata_q  <= cpu.req_wdata;
                wr_bus   <= cpu.req_write;
                rd_bus   <= !cpu.req_write;
            end
            if (finish_ok) begin
                resp_rdata_q <= write_q ? '0 : data_bus;
                resp_err_q   <= 1'b0;
                wr_bus       <= 1'b0;
                rd_bus       <= 1'b0;
            end
            if (finish_to) begin
                resp_rdata_q <= '0;
                resp_err_q   <= 1'b1;
                wr_bus       <= 1'b0;
                rd_bus       <= 1'b0;
            end
        end
    end

    bus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .terminal(cnt_term)
    );

    // Driven from state so an async reset releases the bus immediately.
    assign data_bus = (state == ST_ACCESS && write_q) ? wdata_q : 'z;

    assign cpu.req_ready  = (state == ST_IDLE);
    assign cpu.resp_valid = (state == ST_RELEASE);
    assign cpu.resp_rdata = resp_rdata_q;
    assign cpu.resp_err   = resp_err_q;
    assign cpu.state      = state;

endmodule

// File: tb/tb_cpu_bus_master.sv
// Directed bench: LED-style device model (ctrl@0, status@1, leds@2) plus a
// stub responder that completes on the 16th ACCESS cycle.
module tb_cpu_bus_master;
  import cpu_bus_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] addr_bus;
  wire  [7:0]  data_bus;
  logic        wr_bus;
  logic        rd_bus;
  wire         fc_bus;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  cpu_bus_master_if #(.ADDR_BUS_WIDTH(32), .DATA_BUS_WIDTH(8)) cpu ();

  cpu_bus_master #(
    .ADDR_BUS_WIDTH(32),
    .DATA_BUS_WIDTH(8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cpu     (cpu),
    .addr_bus(addr_bus),
    .data_bus(data_bus),
    .wr_bus  (wr_bus),
    .rd_bus  (rd_bus),
    .fc_bus  (fc_bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // device model
  logic       ctrl_en = 1'b0;
  logic [3:0] leds    = 4'h0;
  logic       wack;
  int         stub_cnt;
  logic       stub_mode;
  logic       slv_oe, slv_fc;
  logic [7:0] slv_rdata;

  always_comb begin
    slv_oe    = 1'b0;
    slv_fc    = 1'b0;
    slv_rdata = 8'h00;
    if (stub_mode) begin
      if (rd_bus && stub_cnt == 15) begin
        slv_oe    = 1'b1;
        slv_fc    = 1'b1;
        slv_rdata = 8'h5A;
      end
    end else if (addr_bus < 32'd3) begin
      if (rd_bus && !wr_bus) begin
        slv_oe = 1'b1;
        slv_fc = 1'b1;
        case (addr_bus[1:0])
          2'd0:    slv_rdata = {7'd0, ctrl_en};
          2'd1:    slv_rdata = 8'h01;
          default: slv_rdata = {4'd0, leds};
        endcase
      end else if (wr_bus && !rd_bus) begin
        slv_fc = wack;
      end
    end
  end

  assign data_bus = slv_oe ? slv_rdata : 8'hzz;
  assign fc_bus   = slv_fc ? 1'b1 : 1'bz;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wack     <= 1'b0;
      stub_cnt <= 0;
    end else begin
      stub_cnt <= rd_bus ? stub_cnt + 1 : 0;
      if (wr_bus && !rd_bus && !stub_mode && addr_bus < 32'd3) begin
        if (!wack) begin
          if (addr_bus[1:0] == 2'd0) ctrl_en <= data_bus[0];
          if (addr_bus[1:0] == 2'd2) leds    <= data_bus[3:0];
        end
        wack <= 1'b1;
      end else begin
        wack <= 1'b0;
      end
    end
  end

  // driver: issue one request from IDLE, wait for the response
  task automatic run_req(input logic w, input logic [31:0] a, input logic [7:0] d,
                         input logic hold, output int lat, output int strobe_cyc,
                         output logic [7:0] bus_first);
    for (int i = 0; i < 8 && !cpu.req_ready; i++) @(negedge clk);
    cpu.req_write = w;
    cpu.req_addr  = a;
    cpu.req_wdata = d;
    cpu.req_valid = 1'b1;
    @(negedge clk);
    if (!hold) cpu.req_valid = 1'b0;
    lat        = 1;
    strobe_cyc = 0;
    bus_first  = data_bus;
    while (lat < 40) begin
      if (wr_bus || rd_bus) strobe_cyc++;
      if (cpu.resp_valid) break;
      @(negedge clk);
      lat++;
    end
  endtask

  int         lat, scyc;
  logic [7:0] bfirst;
  logic       saw_resp;

  initial begin
    rst           = 1'b1;
    stub_mode     = 1'b0;
    cpu.req_valid = 1'b0;
    cpu.req_write = 1'b0;
    cpu.req_addr  = '0;
    cpu.req_wdata = '0;

    // reset state
    @(negedge clk);
    total++; if (cpu.req_ready !== 1'b1) begin bad++; $error("FAIL rst_ready"); end
    total++; if (addr_bus !== 32'h0) begin bad++; $error("FAIL rst_addr"); end
    total++; if (wr_bus !== 1'b0) begin bad++; $error("FAIL rst_wr"); end
    total++; if (rd_bus !== 1'b0) begin bad++; $error("FAIL rst_rd"); end
    total++; if (cpu.resp_valid !== 1'b0) begin bad++; $error("FAIL rst_valid"); end
    total++; if (cpu.resp_rdata !== 8'h00) begin bad++; $error("FAIL rst_rdata"); end
    total++; if (cpu.resp_err !== 1'b0) begin bad++; $error("FAIL rst_err"); end
    total++; if (cpu.state !== ST_IDLE) begin bad++; $error("FAIL rst_state"); end
    rst = 1'b0;
    @(negedge clk);

    // read status register, cycle by cycle
    cpu.req_write = 1'b0;
    cpu.req_addr  = 32'd1;
    cpu.req_valid = 1'b1;
    @(negedge clk);
    cpu.req_valid = 1'b0;
    total++; if (rd_bus !== 1'b1) begin bad++; $error("FAIL rd1_rd_bus"); end
    total++; if (wr_bus !== 1'b0) begin bad++; $error("FAIL rd1_wr_bus"); end
    total++; if (addr_bus !== 32'd1) begin bad++; $error("FAIL rd1_addr"); end
    total++; if (cpu.req_ready !== 1'b0) begin bad++; $error("FAIL rd1_ready"); end
    total++; if (cpu.resp_valid !== 1'b0) begin bad++; $error("FAIL rd1_valid_early"); end
    @(negedge clk);
    exp_q.push_back(8'h01);
    exp_v = exp_q.pop_front();
    total++; if (cpu.resp_valid !== 1'b1) begin bad++; $error("FAIL rd1_valid"); end
    total++; if (cpu.resp_rdata !== exp_v) begin bad++; $error("FAIL rd1_rdata got %0h exp %0h", cpu.resp_rdata, exp_v); end
    total++; if (cpu.resp_err !== 1'b0) begin bad++; $error("FAIL rd1_err"); end
    total++; if (rd_bus !== 1'b0) begin bad++; $error("FAIL rd1_strobe_low"); end
    total++; if (cpu.req_ready !== 1'b0) begin bad++; $error("FAIL rd1_rel_ready"); end
    @(negedge clk);
    total++; if (cpu.resp_valid !== 1'b0) begin bad++; $error("FAIL rd1_pulse_end"); end
    total++; if (cpu.req_ready !== 1'b1) begin bad++; $error("FAIL rd1_idle_ready"); end

    // write LED data
    run_req(1'b1, 32'd2, 8'h05, 1'b0, lat, scyc, bfirst);
    total++; if (lat != 3) begin bad++; $error("FAIL wr_lat got %0d", lat); end
    total++; if (scyc != 2) begin bad++; $error("FAIL wr_strobe_cycles got %0d", scyc); end
    total++; if (bfirst !== 8'h05) begin bad++; $error("FAIL wr_bus_data got %0h", bfirst); end
    total++; if (cpu.resp_err !== 1'b0) begin bad++; $error("FAIL wr_err"); end
    total++; if (cpu.resp_rdata !== 8'h00) begin bad++; $error("FAIL wr_rdata"); end
    total++; if (leds !== 4'h5) begin bad++; $error("FAIL wr_leds got %0h", leds); end

    // read after write: bus must have been released
    run_req(1'b0, 32'd1, 8'h00, 1'b0, lat, scyc, bfirst);
    exp_q.push_back(8'h01);
    exp_v = exp_q.pop_front();
    total++; if (lat != 2) begin bad++; $error("FAIL rd2_lat got %0d", lat); end
    total++; if (cpu.resp_rdata !== exp_v) begin bad++; $error("FAIL rd2_rdata got %0h", cpu.resp_rdata); end

    // back-to-back writes with req_valid held
    run_req(1'b1, 32'd0, 8'h01, 1'b1, lat, scyc, bfirst);
    total++; if (lat != 3) begin bad++; $error("FAIL b2b1_lat got %0d", lat); end
    total++; if (cpu.resp_err !== 1'b0) begin bad++; $error("FAIL b2b1_err"); end
    total++; if (wr_bus !== 1'b0) begin bad++; $error("FAIL b2b1_wr_low_rel"); end
    total++; if (cpu.req_ready !== 1'b0) begin bad++; $error("FAIL b2b1_rel_ready"); end
    cpu.req_addr  = 32'd2;
    cpu.req_wdata = 8'h0F;
    @(negedge clk);
    total++; if (cpu.req_ready !== 1'b1) begin bad++; $error("FAIL b2b_idle_ready"); end
    total++; if (wr_bus !== 1'b0) begin bad++; $error("FAIL b2b_idle_wr_low"); end
    total++; if (addr_bus !== 32'd0) begin bad++; $error("FAIL b2b_idle_addr"); end
    @(negedge clk);
    cpu.req_valid = 1'b0;
    total++; if (wr_bus !== 1'b1) begin bad++; $error("FAIL b2b2_wr_high"); end
    total++; if (addr_bus !== 32'd2) begin bad++; $error("FAIL b2b2_addr"); end
    lat = 1;
    while (lat < 40 && !cpu.resp_valid) begin
      @(negedge clk);
      lat++;
    end
    total++; if (lat != 3) begin bad++; $error("FAIL b2b2_lat got %0d", lat); end
    total++; if (cpu.resp_err !== 1'b0) begin bad++; $error("FAIL b2b2_err"); end
    total++; if (ctrl_en !== 1'b1) begin bad++; $error("FAIL b2b_ctrl_en"); end
    total++; if (leds !== 4'hF) begin bad++; $error("FAIL b2b_leds got %0h", leds); end

    // unmapped address: timeout
    run_req(1'b0, 32'h100, 8'h00, 1'b0, lat, scyc, bfirst);
    total++; if (lat != 17) begin bad++; $error("FAIL to_lat got %0d", lat); end
    total++; if (scyc != 16) begin bad++; $error("FAIL to_strobe_cycles got %0d", scyc); end
    total++; if (cpu.resp_err !== 1'b1) begin bad++; $error("FAIL to_err"); end
    total++; if (cpu.resp_rdata !== 8'h00) begin bad++; $error("FAIL to_rdata"); end
    total++; if (rd_bus !== 1'b0) begin bad++; $error("FAIL to_rd_low"); end
    total++; if (wr_bus !== 1'b0) begin bad++; $error("FAIL to_wr_low"); end

    // fc arrives on the timeout edge: completion wins
    stub_mode = 1'b1;
    run_req(1'b0, 32'h200, 8'h00, 1'b0, lat, scyc, bfirst);
    exp_q.push_back(8'h5A);
    exp_v = exp_q.pop_front();
    total++; if (lat != 17) begin bad++; $error("FAIL race_lat got %0d", lat); end
    total++; if (cpu.resp_err !== 1'b0) begin bad++; $error("FAIL race_err"); end
    total++; if (cpu.resp_rdata !== exp_v) begin bad++; $error("FAIL race_rdata got %0h", cpu.resp_rdata); end
    stub_mode = 1'b0;

    // reset in the middle of a write
    @(negedge clk);
    cpu.req_write = 1'b1;
    cpu.req_addr  = 32'd2;
    cpu.req_wdata = 8'h0A;
    cpu.req_valid = 1'b1;
    @(negedge clk);
    cpu.req_valid = 1'b0;
    total++; if (wr_bus !== 1'b1) begin bad++; $error("FAIL mid_wr_high"); end
    total++; if (data_bus !== 8'h0A) begin bad++; $error("FAIL mid_bus_data got %0h", data_bus); end
    #2 rst = 1'b1;
    #1;
    total++; if (wr_bus !== 1'b0) begin bad++; $error("FAIL mid_rst_wr"); end
    total++; if (rd_bus !== 1'b0) begin bad++; $error("FAIL mid_rst_rd"); end
    total++; if (cpu.resp_valid !== 1'b0) begin bad++; $error("FAIL mid_rst_valid"); end
    total++; if (cpu.req_ready !== 1'b1) begin bad++; $error("FAIL mid_rst_ready"); end
    @(negedge clk);
    rst      = 1'b0;
    saw_resp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      saw_resp = saw_resp | cpu.resp_valid;
    end
    total++; if (saw_resp !== 1'b0) begin bad++; $error("FAIL mid_no_resp"); end
    total++; if (cpu.req_ready !== 1'b1) begin bad++; $error("FAIL mid_ready_after"); end
    total++; if (leds !== 4'hF) begin bad++; $error("FAIL mid_leds_kept got %0h", leds); end

    // recovery read
    run_req(1'b0, 32'd2, 8'h00, 1'b0, lat, scyc, bfirst);
    exp_q.push_back(8'h0F);
    exp_v = exp_q.pop_front();
    total++; if (lat != 2) begin bad++; $error("FAIL rec_lat got %0d", lat); end
    total++; if (cpu.resp_rdata !== exp_v) begin bad++; $error("FAIL rec_rdata got %0h", cpu.resp_rdata); end
    total++; if (cpu.resp_err !== 1'b0) begin bad++; $error("FAIL rec_err"); end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    if (bad == 0) $display("PASS");
    else          $display("FAIL");
    $finish;
  end

endmodule
